// File: rtl/axis_test_pattern_gen_pkg.sv
// rtl/axis_test_pattern_gen_pkg.sv - shared video package: TPG state encoding, pattern selects, helpers
package axis_test_pattern_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACTIVE = 2'd2
    } tpg_state_t;

    localparam logic [1:0] PAT_HRAMP    = 2'd0;
    localparam logic [1:0] PAT_VRAMP    = 2'd1;
    localparam logic [1:0] PAT_CHECKER  = 2'd2;
    localparam logic [1:0] PAT_FRAMENUM = 2'd3;

    // Saturating increment keeps long idle gaps from wrapping the pacing counter.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/tpg_pixel_gen.sv
// rtl/tpg_pixel_gen.sv - combinational pattern function (x, y, frame number, pattern) -> pixel value
module tpg_pixel_gen
    import axis_test_pattern_gen_pkg::*;
#(
    parameter int IMG_WIDTH_MAX   = 16,
    parameter int IMG_HEIGHT_MAX  = 16,
    parameter int AXIS_DATA_WIDTH = 8
)(
    input  logic [IMG_WIDTH_MAX-1:0]   i_x,
    input  logic [IMG_HEIGHT_MAX-1:0]  i_y,
    input  logic [31:0]                i_frame_num,
    input  logic [1:0]                 i_pattern,
    output logic [AXIS_DATA_WIDTH-1:0] o_data
);

    typedef logic [AXIS_DATA_WIDTH-1:0] data_t;

    // Size casts truncate or zero-extend each source to the pixel width.
    always_comb begin
        o_data = '0;
        case (i_pattern)
            PAT_HRAMP:    o_data = data_t'(i_x);
            PAT_VRAMP:    o_data = data_t'(i_y);
            PAT_CHECKER:  o_data = (i_x[3] ^ i_y[3]) ? '1 : '0;
            PAT_FRAMENUM: o_data = data_t'(i_frame_num);
            default:      o_data = '0;
        endcase
    end

endmodule

// File: rtl/axis_test_pattern_gen.sv
// rtl/axis_test_pattern_gen.sv - AXI-Stream video test pattern source; TPG_FRAME_PACING_EN adds frame pacing
module axis_test_pattern_gen
    import axis_test_pattern_gen_pkg::*;
#(
    parameter int IMG_WIDTH_MAX   = 16,
    parameter int IMG_HEIGHT_MAX  = 16,
    parameter int AXIS_DATA_WIDTH = 8
)(
    input  logic                       i_axi_clk,
    input  logic                       i_axi_rst,
    input  logic                       i_enable,
    input  logic [IMG_WIDTH_MAX-1:0]   i_width,
    input  logic [IMG_HEIGHT_MAX-1:0]  i_height,
    input  logic [1:0]                 i_pattern,
    input  logic [31:0]                i_frame_interval,
    output logic                       o_axis_out_tuser,
    output logic                       o_axis_out_tvalid,
    input  logic                       i_axis_out_tready,
    output logic                       o_axis_out_tlast,
    output logic [AXIS_DATA_WIDTH-1:0] o_axis_out_tdata,
    output logic                       o_busy,
    output logic                       o_overrun,
    output logic                       o_cfg_error,
    output logic [31:0]                o_frame_count
);

    typedef logic [IMG_WIDTH_MAX-1:0]  xw_t;
    typedef logic [IMG_HEIGHT_MAX-1:0] yw_t;

    tpg_state_t                 r_state;
    xw_t                        r_x;
    xw_t                        r_width;
    yw_t                        r_y;
    yw_t                        r_height;
    logic [1:0]                 r_pattern;
    logic                       r_tvalid;
    logic                       r_tuser;
    logic                       r_tlast;
    logic [AXIS_DATA_WIDTH-1:0] r_tdata;
    logic                       r_busy;
    logic                       r_overrun;
    logic                       r_cfg_error;
    logic [31:0]                r_frame_count;

    logic                       w_accept;
    logic                       w_row_end;
    logic                       w_frame_end;
    logic                       w_cfg_zero;
    logic                       w_pace_ok;
    logic                       w_overrun_hit;
    logic                       w_launch;
    xw_t                        w_next_x;
    yw_t                        w_next_y;
    xw_t                        w_gen_x;
    yw_t                        w_gen_y;
    xw_t                        w_gen_width;
    logic [1:0]                 w_gen_pattern;
    logic                       w_gen_tlast;
    logic [AXIS_DATA_WIDTH-1:0] w_gen_data;

    assign w_accept    = r_tvalid && i_axis_out_tready;
    assign w_row_end   = (r_x == r_width - xw_t'(1));
    assign w_frame_end = w_row_end && (r_y == r_height - yw_t'(1));
    assign w_next_x    = w_row_end ? '0 : r_x + xw_t'(1);
    assign w_next_y    = w_row_end ? r_y + yw_t'(1) : r_y;
    assign w_cfg_zero  = (i_width == '0) || (i_height == '0);
    assign w_launch    = (r_state == ST_WAIT) && i_enable && w_pace_ok && !w_cfg_zero;

`ifdef TPG_FRAME_PACING_EN
    logic [31:0] r_pace_cnt;

    // Restarts at 1 on the SOF launch cycle so SOFs land exactly one interval apart.
    always_ff @(posedge i_axi_clk) begin
        if (i_axi_rst) begin
            r_pace_cnt <= '0;
        end else if (w_launch) begin
            r_pace_cnt <= 32'd1;
        end else begin
            r_pace_cnt <= sat_inc32(r_pace_cnt);
        end
    end

    assign w_pace_ok     = (r_pace_cnt >= i_frame_interval);
    assign w_overrun_hit = w_pace_ok && (i_frame_interval > 32'd1);
`else
    logic w_unused_interval;

    assign w_unused_interval = ^i_frame_interval;
    assign w_pace_ok         = 1'b1;
    assign w_overrun_hit     = 1'b0;
`endif

    // Outside ACTIVE the generator previews the SOF pixel from the live config inputs.
    assign w_gen_x       = (r_state == ST_ACTIVE) ? w_next_x  : '0;
    assign w_gen_y       = (r_state == ST_ACTIVE) ? w_next_y  : '0;
    assign w_gen_width   = (r_state == ST_ACTIVE) ? r_width   : i_width;
    assign w_gen_pattern = (r_state == ST_ACTIVE) ? r_pattern : i_pattern;
    assign w_gen_tlast   = (w_gen_x == w_gen_width - xw_t'(1));

    tpg_pixel_gen #(
        .IMG_WIDTH_MAX   (IMG_WIDTH_MAX),
        .IMG_HEIGHT_MAX  (IMG_HEIGHT_MAX),
        .AXIS_DATA_WIDTH (AXIS_DATA_WIDTH)
    ) u_pixel_gen (
        .i_x         (w_gen_x),
        .i_y         (w_gen_y),
        .i_frame_num (r_frame_count),
        .i_pattern   (w_gen_pattern),
        .o_data      (w_gen_data)
    );

    always_ff @(posedge i_axi_clk) begin
        if (i_axi_rst) begin
            r_state       <= ST_IDLE;
            r_x           <= '0;
            r_y           <= '0;
            r_width       <= '0;
            r_height      <= '0;
            r_pattern     <= PAT_HRAMP;
            r_tvalid      <= 1'b0;
            r_tuser       <= 1'b0;
            r_tlast       <= 1'b0;
            r_tdata       <= '0;
            r_busy        <= 1'b0;
            r_overrun     <= 1'b0;
            r_cfg_error   <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_overrun <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_cfg_error <= 1'b0;
                    if (i_enable) begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!i_enable) begin
                        r_state     <= ST_IDLE;
                        r_cfg_error <= 1'b0;
                    end else if (w_pace_ok) begin
                        r_cfg_error <= w_cfg_zero;
                        if (!w_cfg_zero) begin
                            r_width   <= i_width;
                            r_height  <= i_height;
                            r_pattern <= i_pattern;
                            r_x       <= '0;
                            r_y       <= '0;
                            r_tvalid  <= 1'b1;
                            r_tuser   <= 1'b1;
                            r_tlast   <= w_gen_tlast;
                            r_tdata   <= w_gen_data;
                            r_busy    <= 1'b1;
                            r_state   <= ST_ACTIVE;
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (w_accept) begin
                        if (w_frame_end) begin
                            r_tvalid      <= 1'b0;
                            r_tuser       <= 1'b0;
                            r_tlast       <= 1'b0;
                            r_busy        <= 1'b0;
                            r_frame_count <= r_frame_count + 32'd1;
                            r_overrun     <= w_overrun_hit;
                            r_state       <= i_enable ? ST_WAIT : ST_IDLE;
                        end else begin
                            r_x     <= w_next_x;
                            r_y     <= w_next_y;
                            r_tuser <= 1'b0;
                            r_tlast <= w_gen_tlast;
                            r_tdata <= w_gen_data;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_axis_out_tuser  = r_tuser;
    assign o_axis_out_tvalid = r_tvalid;
    assign o_axis_out_tlast  = r_tlast;
    assign o_axis_out_tdata  = r_tdata;
    assign o_busy            = r_busy;
    assign o_overrun         = r_overrun;
    assign o_cfg_error       = r_cfg_error;
    assign o_frame_count     = r_frame_count;

endmodule

// File: tb/tb_axis_test_pattern_gen.sv
// tb/tb_axis_test_pattern_gen.sv - directed self-checking bench for axis_test_pattern_gen
module tb_axis_test_pattern_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] width;
    logic [15:0] height;
    logic [1:0]  pat;
    logic [31:0] interval;
    logic        tuser;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic [7:0]  tdata;
    logic        busy;
    logic        overrun;
    logic        cfg_err;
    logic [31:0] fcount;

    int checks = 0;
    int errors = 0;
    int n;
    int seen;
    logic held;
    logic r;
    logic [7:0] hd;
    logic hu;
    logic hl;
    logic [7:0] cap_data[$];
    logic       cap_user[$];
    logic       cap_last[$];

    always #5 clk = ~clk;

    axis_test_pattern_gen #(
        .IMG_WIDTH_MAX   (16),
        .IMG_HEIGHT_MAX  (16),
        .AXIS_DATA_WIDTH (8)
    ) dut (
        .i_axi_clk         (clk),
        .i_axi_rst         (rst),
        .i_enable          (en),
        .i_width           (width),
        .i_height          (height),
        .i_pattern         (pat),
        .i_frame_interval  (interval),
        .o_axis_out_tuser  (tuser),
        .o_axis_out_tvalid (tvalid),
        .i_axis_out_tready (tready),
        .o_axis_out_tlast  (tlast),
        .o_axis_out_tdata  (tdata),
        .o_busy            (busy),
        .o_overrun         (overrun),
        .o_cfg_error       (cfg_err),
        .o_frame_count     (fcount)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one frame with tready high, dropping enable after beat drop_at is seen.
    task automatic collect(input int w, input int h, input logic [1:0] p, input int drop_at);
        cap_data.delete();
        cap_user.delete();
        cap_last.delete();
        width  = 16'(w);
        height = 16'(h);
        pat    = p;
        tready = 1'b1;
        en     = 1'b1;
        for (int c = 0; c < 400 && cap_data.size() < w * h; c++) begin
            @(negedge clk);
            if (tvalid) begin
                cap_data.push_back(tdata);
                cap_user.push_back(tuser);
                cap_last.push_back(tlast);
                if (cap_data.size() == drop_at + 1) en = 1'b0;
            end
        end
        en = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; width = 16'd4; height = 16'd3; pat = 2'd0;
        interval = 32'd0; tready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tvalid", tvalid, 1'b0);
        check("rst_tuser", tuser, 1'b0);
        check("rst_tlast", tlast, 1'b0);
        check("rst_tdata", tdata, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_cfg_error", cfg_err, 1'b0);
        check("rst_frame_count", fcount, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 4x3 horizontal ramp, back-to-back into a second frame
        en = 1'b1;
        n = 0;
        while (!tvalid && n < 10) begin @(negedge clk); n++; end
        check("f1_sof_seen", tvalid, 1'b1);
        for (int i = 0; i < 12; i++) begin
            check("f1_valid", tvalid, 1'b1);
            check("f1_data", tdata, 8'(i % 4));
            check("f1_user", tuser, (i == 0));
            check("f1_last", tlast, (i % 4 == 3));
            @(negedge clk);
        end
        check("f1_gap_valid", tvalid, 1'b0);
        check("f1_gap_busy", busy, 1'b0);
        check("f1_frame_count", fcount, 32'd1);
        check("f1_no_overrun", overrun, 1'b0);
        @(negedge clk);
        check("f2_sof_valid", tvalid, 1'b1);
        check("f2_sof_user", tuser, 1'b1);
        check("f2_sof_data", tdata, 8'h00);
        en = 1'b0;
        n = 0;
        while (tvalid && n < 30) begin @(negedge clk); n++; end
        check("f2_beats", n, 12);
        check("f2_frame_count", fcount, 32'd2);
        repeat (3) @(negedge clk);
        check("f2_idle_valid", tvalid, 1'b0);
        check("f2_idle_busy", busy, 1'b0);

        // vertical ramp 2x3
        collect(2, 3, 2'd1, 0);
        check("vramp_size", cap_data.size(), 6);
        check("vramp_d1", cap_data[1], 8'd0);
        check("vramp_d4", cap_data[4], 8'd2);
        check("vramp_last1", cap_last[1], 1'b1);
        check("vramp_last2", cap_last[2], 1'b0);
        check("vramp_user2", cap_user[2], 1'b0);
        check("vramp_count", fcount, 32'd3);

        // checkerboard 16x1: x[3] flips the pixel
        collect(16, 1, 2'd2, 0);
        check("chk_d7", cap_data[7], 8'h00);
        check("chk_d8", cap_data[8], 8'hFF);
        check("chk_d15", cap_data[15], 8'hFF);
        check("chk_last14", cap_last[14], 1'b0);
        check("chk_last15", cap_last[15], 1'b1);
        check("chk_count", fcount, 32'd4);

        // frame-number pattern, enable dropped at beat 5 of 4x4
        collect(4, 4, 2'd3, 5);
        check("drop_beats", cap_data.size(), 16);
        check("drop_d0", cap_data[0], 8'd4);
        check("drop_d15", cap_data[15], 8'd4);
        check("drop_valid", tvalid, 1'b0);
        check("drop_busy", busy, 1'b0);
        check("drop_count", fcount, 32'd5);

        // random tready throttling on 5x2
        width = 16'd5; height = 16'd2; pat = 2'd0; en = 1'b1; tready = 1'b0;
        n = 0; held = 1'b0;
        for (int c = 0; c < 300 && n < 10; c++) begin
            @(negedge clk);
            if (held) begin
                check("thr_hold_valid", tvalid, 1'b1);
                check("thr_hold_data", tdata, hd);
                check("thr_hold_user", tuser, hu);
                check("thr_hold_last", tlast, hl);
            end
            r = 1'($urandom_range(0, 1));
            held = 1'b0;
            if (tvalid) begin
                if (r) begin
                    check("thr_data", tdata, 8'(n % 5));
                    check("thr_user", tuser, (n == 0));
                    check("thr_last", tlast, (n % 5 == 4));
                    n++;
                    en = 1'b0;
                end else begin
                    held = 1'b1; hd = tdata; hu = tuser; hl = tlast;
                end
            end
            tready = r;
        end
        check("thr_beats", n, 10);
        tready = 1'b1;
        repeat (3) @(negedge clk);
        check("thr_count", fcount, 32'd6);

        // zero width: nothing sent, config error held
        width = 16'd0; height = 16'd2; en = 1'b1;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (tvalid) seen++;
        end
        check("cfg_err_level", cfg_err, 1'b1);
        check("cfg_err_nobeats", seen, 0);
        check("cfg_err_busy", busy, 1'b0);
        en = 1'b0;
        repeat (2) @(negedge clk);

        // reset mid-frame
        width = 16'd4; height = 16'd4; en = 1'b1;
        n = 0;
        while (!tvalid && n < 10) begin @(negedge clk); n++; end
        check("mid_sof_seen", tvalid, 1'b1);
        repeat (3) @(negedge clk);
        check("mid_busy_before", busy, 1'b1);
        rst = 1'b1; en = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", tvalid, 1'b0);
        check("mid_rst_count", fcount, 32'd0);
        check("mid_rst_busy", busy, 1'b0);
        rst = 1'b0;
        @(negedge clk);

`ifdef TPG_FRAME_PACING_EN
        begin
            int sof1;
            int sof2;
            int ovr;
            int ovr_cyc;
            for (int k = 0; k < 2; k++) begin
                interval = (k == 0) ? 32'd100 : 32'd10;
                width = 16'd4; height = 16'd4; pat = 2'd0; tready = 1'b1; en = 1'b1;
                sof1 = -1; sof2 = -1; ovr = 0; ovr_cyc = -1;
                for (int c = 0; c < 600 && sof2 < 0; c++) begin
                    @(negedge clk);
                    if (overrun && sof1 >= 0) begin ovr++; ovr_cyc = c; end
                    if (tvalid && tuser) begin
                        if (sof1 < 0) sof1 = c;
                        else sof2 = c;
                    end
                end
                en = 1'b0;
                n = 0;
                while ((tvalid || busy) && n < 40) begin @(negedge clk); n++; end
                repeat (2) @(negedge clk);
                if (k == 0) begin
                    check("pace100_spacing", sof2 - sof1, 100);
                    check("pace100_overrun", ovr, 0);
                end else begin
                    check("pace10_spacing", sof2 - sof1, 17);
                    check("pace10_overrun", ovr, 1);
                    check("pace10_overrun_cyc", ovr_cyc, sof2 - 1);
                end
            end
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
